// File: rtl/qs_pkg.sv
// qs_pkg: shared types and default widths for the quicksort blocks.
package qs_pkg;
    localparam int QS_DW = 32;
    localparam int QS_AW = 6;
    typedef enum logic [3:0] {
        S_IDLE, S_PIV, S_SADDR, S_SCMP, S_SWR1, S_SWR2,
        S_FRD, S_FWR1, S_FWR2, S_PUSHL, S_PUSHR, S_DONE
    } state_t;
    typedef struct packed {
        logic [QS_AW-1:0] lo;
        logic [QS_AW-1:0] hi;
    } range_t;
endpackage

// File: rtl/partition_unit.sv
// partition_unit: Lomuto partition of RAM[lo..hi] around RAM[hi], pushing non-trivial sub-ranges.
import qs_pkg::*;
module partition_unit #(
    parameter int DW = QS_DW,
    parameter int AW = QS_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] lo,
    input  logic [AW-1:0] hi,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pivot_idx,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          push,
    output logic [AW-1:0] push_lo,
    output logic [AW-1:0] push_hi
);
    state_t        state_q;
    logic [AW-1:0] lo_q, hi_q, i_q, j_q, p_q;
    logic [DW-1:0] pivot_q, aj_q;
    logic [AW:0]   p_x, lo_x, hi_x;
    logic          left_ok, right_ok, push_l, push_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            p_q     <= '0;
            pivot_q <= '0;
            aj_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    lo_q    <= lo;
                    hi_q    <= hi;
                    i_q     <= lo;
                    j_q     <= lo;
                    p_q     <= lo;
                    state_q <= (lo < hi) ? S_PIV : S_DONE;
                end
                S_PIV: begin
                    pivot_q <= mem_rdata;
                    state_q <= S_SADDR;
                end
                S_SADDR: state_q <= (j_q == hi_q) ? S_FRD : S_SCMP;
                S_SCMP: begin
                    if (mem_rdata >= pivot_q) begin
                        j_q     <= j_q + 1'b1;
                        state_q <= S_SADDR;
                    end else if (i_q == j_q) begin
                        i_q     <= i_q + 1'b1;
                        j_q     <= j_q + 1'b1;
                        state_q <= S_SADDR;
                    end else begin
                        aj_q    <= mem_rdata;
                        state_q <= S_SWR1;
                    end
                end
                S_SWR1: state_q <= S_SWR2;
                S_SWR2: begin
                    i_q     <= i_q + 1'b1;
                    j_q     <= j_q + 1'b1;
                    state_q <= S_SADDR;
                end
                S_FRD:  state_q <= S_FWR1;
                S_FWR1: state_q <= S_FWR2;
                S_FWR2: begin
                    p_q     <= i_q;
                    state_q <= S_PUSHL;
                end
                S_PUSHL: state_q <= S_PUSHR;
                S_PUSHR: state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM reads land one cycle later, so each state addresses the word the next state consumes
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE:       mem_addr = (start && lo < hi) ? hi : '0;
            S_SADDR:      mem_addr = (j_q == hi_q) ? i_q : j_q;
            S_SCMP, S_FRD: mem_addr = i_q;
            S_SWR1: begin
                mem_addr  = j_q;
                mem_we    = 1'b1;
                mem_wdata = mem_rdata;
            end
            S_SWR2: begin
                mem_addr  = i_q;
                mem_we    = 1'b1;
                mem_wdata = aj_q;
            end
            S_FWR1: begin
                mem_addr  = hi_q;
                mem_we    = 1'b1;
                mem_wdata = mem_rdata;
            end
            S_FWR2: begin
                mem_addr  = i_q;
                mem_we    = 1'b1;
                mem_wdata = pivot_q;
            end
            default: ;
        endcase
    end

    // one extra bit keeps lo+1 and p+1 from wrapping at the top index
    assign p_x       = {1'b0, p_q};
    assign lo_x      = {1'b0, lo_q};
    assign hi_x      = {1'b0, hi_q};
    assign left_ok   = p_x > lo_x + 1'b1;
    assign right_ok  = hi_x > p_x + 1'b1;
    assign push_l    = (state_q == S_PUSHL) && left_ok;
    assign push_r    = (state_q == S_PUSHR) && right_ok;
    assign push      = push_l || push_r;
    assign push_lo   = push_l ? lo_q : push_r ? p_q + 1'b1 : '0;
    assign push_hi   = push_l ? p_q - 1'b1 : push_r ? hi_q : '0;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = state_q == S_DONE;
    assign pivot_idx = p_q;
endmodule

// File: tb/tb_partition_unit.sv
// tb_partition_unit: directed checks of the partition engine with a RAM model and a modelled range stack.
import qs_pkg::*;
module tb_partition_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  lo = '0, hi = '0;
    logic        busy, done, mem_we, push;
    logic [5:0]  pivot_idx, mem_addr, push_lo, push_hi;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] ram [64];
    logic        ld_we = 1'b0;
    logic [5:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    range_t      pq [$];
    int          we_cnt = 0, done_cnt = 0;
    int          checks = 0, errors = 0;

    partition_unit dut (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .busy(busy), .done(done), .pivot_idx(pivot_idx),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .push(push), .push_lo(push_lo), .push_hi(push_hi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_we) ram[ld_addr] <= ld_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) begin
        if (!rst && push) pq.push_back(range_t'{push_lo, push_hi});
        if (!rst && mem_we) we_cnt <= we_cnt + 1;
        if (!rst && done) done_cnt <= done_cnt + 1;
    end

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic run(input logic [5:0] l, input logic [5:0] h, output int cyc);
        start = 1'b1; lo = l; hi = h;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL run_timeout lo=%0d hi=%0d: done=%b after %0d cycles, required 1", l, h, done, cyc);
        end
        @(negedge clk);
    endtask

    task automatic check_ram4(input string name, input logic [31:0] e0, e1, e2, e3);
        logic [127:0] got, exp;
        got = {ram[0], ram[1], ram[2], ram[3]};
        exp = {e0, e1, e2, e3};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s ram[0..3]: got %0d %0d %0d %0d, required %0d %0d %0d %0d",
                     name, ram[0], ram[1], ram[2], ram[3], e0, e1, e2, e3);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, push, mem_we, pivot_idx, mem_addr, mem_wdata, push_lo, push_hi} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b push=%b we=%b pidx=%0d addr=%0d wdata=%0d plo=%0d phi=%0d, required all 0",
                     busy, done, push, mem_we, pivot_idx, mem_addr, mem_wdata, push_lo, push_hi);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc, n0, w0, d0;
        load(0, 3); load(1, 1); load(2, 4); load(3, 2); load(4, 32'hAA);
        n0 = pq.size(); w0 = we_cnt; d0 = done_cnt;
        run(0, 3, cyc);
        check_ram4("basic", 1, 2, 4, 3);
        checks++;
        if (pivot_idx !== 6'd1) begin errors++; $display("FAIL basic_pivot: got %0d, required 1", pivot_idx); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d, required 1", done_cnt - d0); end
        checks++;
        if (pq.size() - n0 != 1 || pq[pq.size()-1] !== range_t'{6'd2, 6'd3}) begin
            errors++;
            $display("FAIL basic_push: count %0d, required 1 push of (2,3)", pq.size() - n0);
        end
        checks++;
        if (we_cnt - w0 != 4) begin errors++; $display("FAIL basic_writes: got %0d, required 4", we_cnt - w0); end
        checks++;
        if (ram[4] !== 32'hAA) begin errors++; $display("FAIL basic_outside: ram[4]=%0h, required aa", ram[4]); end
    endtask

    task automatic test_pivot_max();
        int cyc, n0, w0;
        load(0, 5); load(1, 6); load(2, 7);
        n0 = pq.size(); w0 = we_cnt;
        run(0, 2, cyc);
        checks++;
        if ({ram[0], ram[1], ram[2]} !== {32'd5, 32'd6, 32'd7}) begin
            errors++;
            $display("FAIL max_ram: got %0d %0d %0d, required 5 6 7", ram[0], ram[1], ram[2]);
        end
        checks++;
        if (pivot_idx !== 6'd2) begin errors++; $display("FAIL max_pivot: got %0d, required 2", pivot_idx); end
        checks++;
        if (we_cnt - w0 != 2) begin errors++; $display("FAIL max_writes: got %0d, required 2", we_cnt - w0); end
        checks++;
        if (pq.size() - n0 != 1 || pq[pq.size()-1] !== range_t'{6'd0, 6'd1}) begin
            errors++;
            $display("FAIL max_push: count %0d, required 1 push of (0,1)", pq.size() - n0);
        end
    endtask

    task automatic test_pivot_min();
        int cyc, n0;
        load(0, 9); load(1, 8); load(2, 7); load(3, 1);
        n0 = pq.size();
        run(0, 3, cyc);
        check_ram4("min", 1, 8, 7, 9);
        checks++;
        if (pivot_idx !== 6'd0) begin errors++; $display("FAIL min_pivot: got %0d, required 0", pivot_idx); end
        checks++;
        if (pq.size() - n0 != 1 || pq[pq.size()-1] !== range_t'{6'd1, 6'd3}) begin
            errors++;
            $display("FAIL min_push: count %0d, required 1 push of (1,3)", pq.size() - n0);
        end
    endtask

    task automatic test_trivial(input logic [5:0] l, input logic [5:0] h);
        int cyc, n0, w0;
        n0 = pq.size(); w0 = we_cnt;
        run(l, h, cyc);
        checks++;
        if (cyc > 1) begin errors++; $display("FAIL trivial_latency lo=%0d hi=%0d: got %0d, required <=1", l, h, cyc); end
        checks++;
        if (we_cnt != w0 || pq.size() != n0) begin
            errors++;
            $display("FAIL trivial_side_effects lo=%0d hi=%0d: writes %0d pushes %0d, required 0 0", l, h, we_cnt - w0, pq.size() - n0);
        end
        checks++;
        if (pivot_idx !== l) begin errors++; $display("FAIL trivial_pivot: got %0d, required %0d", pivot_idx, l); end
    endtask

    task automatic test_async_reset();
        int cyc, n0;
        load(0, 3); load(1, 1); load(2, 4); load(3, 2);
        n0 = pq.size();
        start = 1'b1; lo = 0; hi = 3;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (mem_we !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL arst_reach_swr1: we=%b, required 1", mem_we); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, push, mem_we, pivot_idx, mem_addr, mem_wdata, push_lo, push_hi} !== '0) begin
            errors++;
            $display("FAIL arst_outputs: busy=%b done=%b push=%b we=%b pidx=%0d addr=%0d wdata=%0d, required all 0",
                     busy, done, push, mem_we, pivot_idx, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pq.size() != n0) begin errors++; $display("FAIL arst_no_push: got %0d pushes, required 0", pq.size() - n0); end
        load(0, 3); load(1, 1); load(2, 4); load(3, 2);
        run(0, 3, cyc);
        check_ram4("arst_rerun", 1, 2, 4, 3);
        checks++;
        if (pivot_idx !== 6'd1) begin errors++; $display("FAIL arst_rerun_pivot: got %0d, required 1", pivot_idx); end
    endtask

    task automatic test_full_sort();
        logic [31:0] exp [16];
        logic [31:0] t;
        range_t      stk [64];
        int          sp, iter, base, cyc, bad_push, bad_ord;
        for (int k = 0; k < 16; k++) begin
            exp[k] = $urandom_range(0, 99);
            load(6'(k), exp[k]);
        end
        for (int a = 0; a < 15; a++)
            for (int b = 0; b < 15 - a; b++)
                if (exp[b] > exp[b+1]) begin t = exp[b]; exp[b] = exp[b+1]; exp[b+1] = t; end
        stk[0] = range_t'{6'd0, 6'd15};
        sp = 1; iter = 0; bad_push = 0;
        while (sp > 0 && iter < 200) begin
            sp--;
            base = pq.size();
            run(stk[sp].lo, stk[sp].hi, cyc);
            for (int k = base; k < pq.size(); k++) begin
                if (pq[k].lo >= pq[k].hi) bad_push++;
                if (sp < 64) begin stk[sp] = pq[k]; sp++; end
            end
            iter++;
        end
        checks++;
        if (sp != 0) begin errors++; $display("FAIL sort_stack_empty: depth %0d after %0d ranges, required 0", sp, iter); end
        checks++;
        if (bad_push != 0) begin errors++; $display("FAIL sort_push_order: %0d pushes with lo>=hi, required 0", bad_push); end
        bad_ord = 0;
        for (int k = 0; k < 16; k++) if (ram[k] !== exp[k]) bad_ord++;
        checks++;
        if (bad_ord != 0) begin errors++; $display("FAIL sort_result: %0d words differ from sorted input, required 0", bad_ord); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pivot_max();
        test_pivot_min();
        test_trivial(6'd5, 6'd5);
        test_trivial(6'd7, 6'd3);
        test_async_reset();
        test_full_sort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/partition_unit.md
Name: partition_unit

Overview:
- Lomuto partition engine for the hardware quicksort. It sits between the range stack's pop side and its push side.
- It takes one (lo, hi) range popped from the stack and partitions array RAM[lo..hi] in place around pivot RAM[hi].
- It then pushes the non-trivial sub-ranges (lo, p-1) and (p+1, hi) back to the stack as val1/val2 pairs.
- The top-level quicksort controller sequences pop -> start -> done until the stack reports empty.

Parameters:
- DW, 32: data word width (matches stack word and array element width).
- AW, 6: array address/index width (2^AW = 64 entries, equal to stack depth N).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request, sampled only in IDLE.
- lo  input  AW  range low index, captured on accepted start.
- hi  input  AW  range high index, captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the partition and its pushes are complete.
- pivot_idx  output  AW  final pivot position p; valid with done and held until the next start.
- mem_addr  output  AW  array RAM address.
- mem_we  output  1  array RAM write enable.
- mem_wdata  output  DW  array RAM write data.
- mem_rdata  input  DW  array RAM read data, synchronous read with 1-cycle latency.
- push  output  1  one-cycle push strobe to the range stack.
- push_lo  output  AW  sub-range low, to stack val1 (zero-extended to stack width at top level).
- push_hi  output  AW  sub-range high, to stack val2.

Behaviour:
- Reset (async, immediate): state=IDLE.
  - busy, done, push, and mem_we are 0.
  - pivot_idx, mem_addr, mem_wdata, push_lo, and push_hi are 0.
  - Reset mid-operation abandons the partition; the RAM may be left partially permuted. No pushes are issued.
- Element comparison is unsigned, strict less-than: RAM[j] < pivot.
- FSM states:
  - IDLE:
    - On start with lo>=hi: go to DONE. No RAM access, no push, pivot_idx=lo.
    - On start with lo<hi: latch lo and hi, set i=j=lo, drive mem_addr=hi, go to PIV.
  - PIV: pivot<=mem_rdata; go to SADDR.
  - SADDR:
    - If j==hi: mem_addr=i, go to FRD.
    - Else: mem_addr=j, go to SCMP.
  - SCMP (aj=mem_rdata):
    - If aj>=pivot: j++, go to SADDR.
    - Else if i==j: i++, j++, go to SADDR.
    - Else: hold aj, mem_addr=i, go to SWR1.
  - SWR1: write RAM[j]=mem_rdata (old A[i]); go to SWR2.
  - SWR2: write RAM[i]=aj; i++, j++, go to SADDR.
  - FRD: wait for A[i]; go to FWR1.
  - FWR1: write RAM[hi]=mem_rdata; go to FWR2.
    - If i==hi, FWR1 and FWR2 still execute; the writes are idempotent.
  - FWR2: write RAM[i]=pivot; pivot_idx=i; go to PUSHL.
  - PUSHL: if p>lo+1, push=1 with (lo, p-1); go to PUSHR.
    - Compare p>lo and p-1>lo without underflow: p-1 is never formed when p==0.
  - PUSHR: if hi>p+1, push=1 with (p+1, hi); go to DONE.
    - p+1 is never formed when p==hi.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Single-element and empty sub-ranges are never pushed.
- Left sub-range is pushed before right, so the stack pops the right sub-range first.
- start asserted while busy is ignored; lo/hi changes while busy have no effect.
- mem_we is asserted only in SWR1, SWR2, FWR1, and FWR2. mem_wdata is don't-care (drive 0) otherwise.
- At most one RAM access per cycle.
- Multiset of RAM[lo..hi] is preserved at done. RAM outside [lo..hi] is never written.
- Post-condition: RAM[lo..p-1] < RAM[p] <= RAM[p+1..hi].

Decomposition:
- Package qs_pkg holds:
  - the FSM state enum;
  - the DW/AW default constants shared with the stack;
  - a range_t struct {lo, hi}.
- No sub-module is needed. The compare/index datapath stays inline.
- The RAM model and stack are separate blocks wired at the quicksort top.

Test Plan:
1. RAM[0..3]={3,1,4,2}, start lo=0 hi=3:
   - Required: RAM={1,2,4,3}, pivot_idx=1, done pulses once.
   - Required: no push for (0,0); push (2,3) observed.
2. RAM[0..2]={5,6,7}, lo=0 hi=2 (pivot is the maximum):
   - Required: RAM unchanged, pivot_idx=2, no swaps in SCMP.
   - Required: one push (0,1); no right push.
3. RAM[0..3]={9,8,7,1}, lo=0 hi=3 (pivot is the minimum, p=0):
   - Required: RAM={1,8,7,9}, pivot_idx=0, single push (1,3), no underflow.
4. start lo=5 hi=5, then start lo=7 hi=3:
   - Required: each yields done within 2 cycles with zero mem_we, zero push, and pivot_idx equal to lo.
5. Assert rst for 1 cycle during SWR1 of scenario 1:
   - Required: outputs 0 in the same cycle (async) and state IDLE.
   - Required: a subsequent start lo=0 hi=3 completes normally.
6. Integrated with stack (N=64) and top controller on a 16-entry random array:
   - Required: RAM fully ascending and stack empty when the controller halts.
   - Required: no push ever has push_lo>=push_hi.
